// File: rtl/sid_lookup_sched.sv
// Time-multiplexes one shared SID table port across waveform and filter/DAC lookups per 1 MHz tick.
// SID_LOOKUP_SCHED_DUAL_EN selects two chips (8 slots); undefined gives one chip (4 slots) mirrored.
module sid_lookup_sched #(
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce_1m,
    input  logic [1:0]   mode,
    input  logic [3:0]   cfg,
    input  logic [71:0]  acc_ps,
    input  logic [71:0]  acc_t,
    input  logic [21:0]  fc,
    input  logic [15:0]  vol,
    output logic         tbl_mode,
    output logic [1:0]   tbl_cfg,
    output logic [11:0]  tbl_acc_ps,
    output logic [11:0]  tbl_acc_t,
    output logic [10:0]  tbl_fc,
    output logic [7:0]   tbl_dac_addr,
    input  logic [31:0]  tbl_wave,
    input  logic [17:0]  tbl_f0,
    input  logic [17:0]  tbl_dac,
    output logic [191:0] wave_out,
    output logic [35:0]  f0_out,
    output logic [35:0]  dac_out,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

`ifdef SID_LOOKUP_SCHED_DUAL_EN
    localparam int NSLOT = 8;
    localparam int NV    = 6;
    localparam int NC    = 2;
`else
    localparam int NSLOT = 4;
    localparam int NV    = 3;
    localparam int NC    = 1;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e               state_q, state_d;
    logic [2:0]           slot_q, slot_d;
    logic [LAT-1:0]       vld_q, vld_d;
    logic [3*LAT-1:0]     tag_q, tag_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;

    logic                 tmode_q, tmode_d;
    logic [1:0]           tcfg_q, tcfg_d;
    logic [11:0]          tps_q, tps_d;
    logic [11:0]          tt_q, tt_d;
    logic [10:0]          tfc_q, tfc_d;
    logic [7:0]           tdac_q, tdac_d;

    logic [32*NV-1:0]     wave_q, wave_d;
    logic [18*NC-1:0]     f0_q, f0_d;
    logic [18*NC-1:0]     dac_q, dac_d;

    logic                 issue;
    logic                 flush;
    logic                 is_voice;
    logic                 chip_sel;
    logic                 cap_vld;
    logic [2:0]           cap_slot;

    // Slot decode for the slot currently being issued.
    always_comb begin
        is_voice = (slot_q < 3'(NV));
`ifdef SID_LOOKUP_SCHED_DUAL_EN
        chip_sel = is_voice ? (slot_q >= 3'd3) : slot_q[0];
`else
        chip_sel = 1'b0;
`endif
    end

    assign issue    = (state_q == StIssue) && !ce_1m;
    assign flush    = ce_1m && (state_q != StIdle);
    assign cap_vld  = vld_q[LAT-1];
    assign cap_slot = tag_q[3*LAT-1 -: 3];

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        // The response arriving this cycle is still taken even if ce_1m flushes the pipe.
        vld_d       = vld_q << 1;
        vld_d[0]    = issue;
        tag_d       = tag_q << 3;
        tag_d[2:0]  = slot_q;
        if (flush) begin
            vld_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (ce_1m) begin
                    state_d = StIssue;
                    slot_d  = 3'd0;
                end
            end
            StIssue: begin
                if (ce_1m) begin
                    slot_d = 3'd0;
                    ovr_d  = 1'b1;
                end else if (slot_q == 3'(NSLOT - 1)) begin
                    state_d = StDrain;
                    slot_d  = 3'd0;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            StDrain: begin
                if (ce_1m) begin
                    state_d = StIssue;
                    slot_d  = 3'd0;
                    ovr_d   = 1'b1;
                end else if (cap_vld && (cap_slot == 3'(NSLOT - 1))) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                slot_d  = 3'd0;
            end
        endcase

        busy_d = (state_d != StIdle) || done_d;
    end

    always_comb begin
        tmode_d = tmode_q;
        tcfg_d  = tcfg_q;
        tps_d   = tps_q;
        tt_d    = tt_q;
        tfc_d   = tfc_q;
        tdac_d  = tdac_q;
        if (issue) begin
            tmode_d = mode[chip_sel];
            tcfg_d  = chip_sel ? cfg[3:2] : cfg[1:0];
            if (is_voice) begin
                for (int k = 0; k < 6; k++) begin
                    if (slot_q == 3'(k)) begin
                        tps_d = acc_ps[12*k +: 12];
                        tt_d  = acc_t[12*k +: 12];
                    end
                end
            end else begin
                tfc_d  = chip_sel ? fc[21:11] : fc[10:0];
                tdac_d = chip_sel ? vol[15:8] : vol[7:0];
            end
        end
    end

    always_comb begin
        wave_d = wave_q;
        f0_d   = f0_q;
        dac_d  = dac_q;
        if (cap_vld) begin
            if (cap_slot < 3'(NV)) begin
                for (int k = 0; k < NV; k++) begin
                    if (cap_slot == 3'(k)) begin
                        wave_d[32*k +: 32] = tbl_wave;
                    end
                end
            end else begin
                for (int k = 0; k < NC; k++) begin
                    if (cap_slot == 3'(NV + k)) begin
                        f0_d[18*k +: 18]  = tbl_f0;
                        dac_d[18*k +: 18] = tbl_dac;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            slot_q  <= 3'd0;
            vld_q   <= '0;
            tag_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tmode_q <= 1'b0;
            tcfg_q  <= 2'd0;
            tps_q   <= 12'd0;
            tt_q    <= 12'd0;
            tfc_q   <= 11'd0;
            tdac_q  <= 8'd0;
            wave_q  <= '0;
            f0_q    <= '0;
            dac_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            tmode_q <= tmode_d;
            tcfg_q  <= tcfg_d;
            tps_q   <= tps_d;
            tt_q    <= tt_d;
            tfc_q   <= tfc_d;
            tdac_q  <= tdac_d;
            wave_q  <= wave_d;
            f0_q    <= f0_d;
            dac_q   <= dac_d;
        end
    end

    assign tbl_mode     = tmode_q;
    assign tbl_cfg      = tcfg_q;
    assign tbl_acc_ps   = tps_q;
    assign tbl_acc_t    = tt_q;
    assign tbl_fc       = tfc_q;
    assign tbl_dac_addr = tdac_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = ovr_q;

`ifdef SID_LOOKUP_SCHED_DUAL_EN
    assign wave_out = wave_q;
    assign f0_out   = f0_q;
    assign dac_out  = dac_q;
`else
    assign wave_out = {wave_q, wave_q};
    assign f0_out   = {f0_q, f0_q};
    assign dac_out  = {dac_q, dac_q};
`endif

endmodule

// File: doc/sid_lookup_sched.md
SID_LOOKUP_SCHED -- requirements
Module: sid_lookup_sched

Interface
REQ-001 SHALL have parameter LAT, default 2: read latency of the shared table port in clk cycles, legal range 1..4.
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce_1m  input  1  1 MHz sample strobe, one clk wide; starts a lookup round.
REQ-005 SHALL have port mode  input  2  per-chip model select, bit i = chip i (0=6581, 1=8580).
REQ-006 SHALL have port cfg  input  4  per-chip filter config, bits [2i+1:2i] = chip i.
REQ-007 SHALL have port acc_ps, acc_t  input  72 each  six 12-bit accumulators, bits [12k+11:12k] = voice k; k=0..2 chip 0, k=3..5 chip 1.
REQ-008 SHALL have port fc  input  22  per-chip 11-bit filter cutoff, bits [11i+10:11i].
REQ-009 SHALL have port vol  input  16  per-chip Mode_Vol byte (DAC address), bits [8i+7:8i].
REQ-010 SHALL have ports tbl_mode 1, tbl_cfg 2, tbl_acc_ps 12, tbl_acc_t 12, tbl_fc 11, tbl_dac_addr 8, all outputs: shared table request fields.
REQ-011 SHALL have ports tbl_wave 32 (_st,p_t,ps_,pst bytes, low to high), tbl_f0 18, tbl_dac 18, all inputs: table responses.
REQ-012 SHALL have ports wave_out 192, f0_out 36, dac_out 36, all outputs: per-requester registered results, same packing as inputs.
REQ-013 SHALL have outputs busy 1 (round in progress), done 1 (one-clk pulse at round end), overrun 1 (sticky).

Function
REQ-014 Slots per round SHALL be: 0..5 = voice 0..5 waveform lookup; 6 = chip 0 filter/DAC; 7 = chip 1 filter/DAC (NSLOT=8).
REQ-015 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on ce_1m, ISSUE->DRAIN after slot NSLOT-1 issued, DRAIN->IDLE when last tag captured.
REQ-016 In ISSUE exactly one slot SHALL be issued per clk, slot 0 in the cycle after ce_1m is sampled.
REQ-017 Issued request fields SHALL be registered outputs; tbl_mode/tbl_cfg SHALL equal the issuing slot's chip; unused fields SHALL hold their previous value.
REQ-018 A LAT-deep tag pipeline (valid + 3-bit slot) SHALL track requests; a response SHALL be captured exactly LAT cycles after its request fields appear at the outputs.
REQ-019 Voice slots SHALL capture tbl_wave; chip slots SHALL capture tbl_f0 into f0_out and tbl_dac into dac_out.
REQ-020 done SHALL pulse in the cycle after the last capture; ce_1m to done = NSLOT + LAT + 1 cycles; busy high from the cycle after ce_1m until done, inclusive.
REQ-021 ce_1m while busy SHALL set overrun, flush all tag valids (no capture of in-flight data), and restart at slot 0; results already captured SHALL be kept.
REQ-022 ce_1m coincident with done SHALL start a new round without setting overrun.
REQ-023 Inputs SHALL be sampled at issue time of each slot, not snapshotted at ce_1m.
REQ-024 overrun SHALL clear only on reset.

Reset
REQ-025 reset SHALL force IDLE, slot counter 0, all tag valids 0, busy/done/overrun 0, all tbl_* outputs 0, wave_out/f0_out/dac_out 0.
REQ-026 reset SHALL take priority over ce_1m in the same cycle; a round interrupted by reset SHALL produce no done.

Configuration
REQ-027 Macro SID_LOOKUP_SCHED_DUAL_EN defined: NSLOT=8 as in REQ-014.
REQ-028 Macro undefined: NSLOT=4 (slots 0..2 voices 0..2, slot 3 chip 0); chip-1 result bits SHALL mirror chip-0 results; ce_1m to done = 4 + LAT + 1.

Verification
REQ-029 LAT=2, dual: ce_1m once, table model returns acc_ps value -> wave_out[k] holds voice k data, done exactly 11 cycles after ce_1m, overrun 0.
REQ-030 mode=2'b10, cfg=4'b0110: check tbl_mode=0/tbl_cfg=2'b10 on slots 0..2,6 and tbl_mode=1/tbl_cfg=2'b01 on slots 3..5,7.
REQ-031 fc chip0=11'h155, vol chip0=8'h0F, table returns f0=fc*3, dac=vol<<4 -> f0_out[17:0]=18'h3FF, dac_out[17:0]=18'h0F0.
REQ-032 Second ce_1m 5 cycles after first -> overrun=1, slots 3..5 of first round never captured, single done 11 cycles after second ce_1m.
REQ-033 reset asserted at slot 4 -> all outputs 0 next cycle, no done; following ce_1m completes a normal round.
REQ-034 Macro undefined, LAT=1: done 6 cycles after ce_1m; f0_out[35:18] equals f0_out[17:0].
